// File: rtl/stream_hub_arbiter_pkg.sv
// Shared arbitration-mode constants, arbiter state encoding and an index-width helper
// for the stream hub.
package stream_hub_arbiter_pkg;

    localparam int MODE_RR   = 0;
    localparam int MODE_PRIO = 1;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Index width that stays legal (>=1 bit) for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_hub_arbiter_if.sv
// Stream bundle between the process channels, the hub and the shared sink.
interface stream_hub_arbiter_if
    import stream_hub_arbiter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32
);
    localparam int CW = idx_w(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_stb;
    logic [N_CH-1:0]       in_ack;
    logic [WIDTH-1:0]      out_data;
    logic [CW-1:0]         out_chan;
    logic                  out_stb;
    logic                  out_ack;

    modport slave  (input  in_data, in_stb, out_ack,
                    output in_ack, out_data, out_chan, out_stb);
    modport master (output in_data, in_stb, out_ack,
                    input  in_ack, out_data, out_chan, out_stb);
endinterface

// File: rtl/stream_hub_fifo.sv
// Small output FIFO with occupancy count; head word reads as zero while empty.
module stream_hub_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/stream_hub_arbiter.sv
// N-channel stb/ack merge with round-robin or fixed-priority arbitration, burst lock and an
// output FIFO, plus a sticky maskable exception aggregator with first-cause capture.
module stream_hub_arbiter
    import stream_hub_arbiter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int MODE  = MODE_RR,
    parameter int BURST = 1,
    parameter int N_EXC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    stream_hub_arbiter_if.slave      strm,
    input  logic [N_EXC-1:0]         exc_in_i,
    input  logic [N_EXC-1:0]         exc_mask_i,
    input  logic                     exc_clear_i,
    output logic                     exception_o,
    output logic [idx_w(N_EXC)-1:0]  exc_first_o,
    output logic                     exc_first_vld_o
);
    localparam int CW = idx_w(N_CH);
    localparam int EW = idx_w(N_EXC);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = idx_w(BURST + 1);

    arb_state_e          state_q;
    logic [CW-1:0]       rr_q, lock_q, grant_idx;
    logic [BW-1:0]       burst_cnt_q;
    logic                active_q, grant_vld, full, push, pop;
    logic [AW:0]         fifo_count;
    logic [CW+WIDTH-1:0] fifo_rdata;
    logic [WIDTH-1:0]    ch_data [N_CH];

    function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] c);
        return (c == CW'(N_CH - 1)) ? '0 : c + 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign ch_data[gi] = strm.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        logic [CW-1:0] idx;
        idx       = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        if (state_q == LOCK) begin
            grant_idx = lock_q;
            grant_vld = strm.in_stb[lock_q];
        end else begin
            // Scanning downward lets the first requester at/after the start point win.
            for (int k = N_CH - 1; k >= 0; k--) begin
                idx = CW'((MODE == MODE_PRIO) ? k : (int'(rr_q) + k) % N_CH);
                if (strm.in_stb[idx]) begin
                    grant_idx = idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // active_q holds acks off while in reset and for the first cycle out of it.
    assign full = (fifo_count == (AW+1)'(DEPTH));
    assign push = active_q && !full && grant_vld;
    assign pop  = strm.out_stb && strm.out_ack;

    always_comb begin
        strm.in_ack = '0;
        if (push) strm.in_ack[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            rr_q        <= '0;
            lock_q      <= '0;
            burst_cnt_q <= '0;
            active_q    <= 1'b0;
        end else begin
            active_q <= 1'b1;
            case (state_q)
                ARB: begin
                    if (push) begin
                        if (BURST > 1) begin
                            state_q     <= LOCK;
                            lock_q      <= grant_idx;
                            burst_cnt_q <= BW'(1);
                        end else begin
                            rr_q <= next_ch(grant_idx);
                        end
                    end
                end
                LOCK: begin
                    if (!grant_vld || (push && burst_cnt_q == BW'(BURST - 1))) begin
                        state_q     <= ARB;
                        burst_cnt_q <= '0;
                        rr_q        <= next_ch(lock_q);
                    end else if (push) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    stream_hub_fifo #(.W(CW + WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({grant_idx, ch_data[grant_idx]}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign strm.out_stb  = (fifo_count != '0);
    assign strm.out_chan = fifo_rdata[CW+WIDTH-1 -: CW];
    assign strm.out_data = fifo_rdata[WIDTH-1:0];

    logic [N_EXC-1:0] exc_sticky_q, exc_sticky_d;
    logic [EW-1:0]    exc_first_q, exc_first_d, exc_lowest;
    logic             exc_first_vld_q, exc_first_vld_d, exception_q;

    always_comb begin
        exc_lowest = '0;
        for (int k = N_EXC - 1; k >= 0; k--) begin
            if (exc_in_i[k]) exc_lowest = EW'(k);
        end
        // New exceptions override a clear arriving in the same cycle.
        exc_sticky_d    = (exc_clear_i ? '0 : exc_sticky_q) | exc_in_i;
        exc_first_vld_d = exc_clear_i ? 1'b0 : exc_first_vld_q;
        exc_first_d     = exc_first_q;
        if (!exc_first_vld_d && (|exc_in_i)) begin
            exc_first_vld_d = 1'b1;
            exc_first_d     = exc_lowest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_sticky_q    <= '0;
            exc_first_q     <= '0;
            exc_first_vld_q <= 1'b0;
            exception_q     <= 1'b0;
        end else begin
            exc_sticky_q    <= exc_sticky_d;
            exc_first_q     <= exc_first_d;
            exc_first_vld_q <= exc_first_vld_d;
            exception_q     <= |(exc_sticky_d & ~exc_mask_i);
        end
    end

    assign exception_o     = exception_q;
    assign exc_first_o     = exc_first_q;
    assign exc_first_vld_o = exc_first_vld_q;

endmodule

// File: tb/tb_stream_hub_arbiter.sv
// Scoreboard bench for stream_hub_arbiter: three instances (round robin, fixed priority,
// burst of 3) share one stimulus; the instance under test is picked by sel.
module tb_stream_hub_arbiter;
    import stream_hub_arbiter_pkg::*;

    localparam int NC = 4;
    localparam int W  = 32;

    typedef struct packed {
        logic [1:0]   chan;
        logic [W-1:0] data;
    } word_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [NC*W-1:0] in_data;
    logic [NC-1:0]   in_stb;
    logic            out_ack;
    logic [3:0]      exc_in, exc_mask;
    logic            exc_clear;
    logic [1:0]      sel;

    logic [2:0][NC-1:0] ack_a;
    logic [2:0]         stb_a, exc_a, vld_a;
    logic [2:0][W-1:0]  data_a;
    logic [2:0][1:0]    chan_a, first_a;

    logic [NC-1:0] ack_obs, ack_hist;
    logic          stb_obs, exc_obs, vld_obs;
    logic [W-1:0]  data_obs;
    logic [1:0]    chan_obs, first_obs;

    int    seq [NC];
    int    exp_seq [NC];
    int    n_xfer;
    int    n_checks = 0;
    int    n_fail   = 0;
    word_t exp_q[$];
    word_t got_q[$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        stream_hub_arbiter_if #(.N_CH(NC), .WIDTH(W)) bus ();
        assign bus.in_data = in_data;
        assign bus.in_stb  = in_stb;
        assign bus.out_ack = out_ack;
        assign ack_a[gi]   = bus.in_ack;
        assign stb_a[gi]   = bus.out_stb;
        assign data_a[gi]  = bus.out_data;
        assign chan_a[gi]  = bus.out_chan;

        stream_hub_arbiter #(
            .N_CH(NC), .WIDTH(W), .DEPTH(4),
            .MODE((gi == 1) ? MODE_PRIO : MODE_RR),
            .BURST((gi == 2) ? 3 : 1), .N_EXC(4)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .strm            (bus),
            .exc_in_i        (exc_in),
            .exc_mask_i      (exc_mask),
            .exc_clear_i     (exc_clear),
            .exception_o     (exc_a[gi]),
            .exc_first_o     (first_a[gi]),
            .exc_first_vld_o (vld_a[gi])
        );
    end

    assign ack_obs   = ack_a[sel];
    assign stb_obs   = stb_a[sel];
    assign data_obs  = data_a[sel];
    assign chan_obs  = chan_a[sel];
    assign exc_obs   = exc_a[sel];
    assign vld_obs   = vld_a[sel];
    assign first_obs = first_a[sel];

    function automatic logic [W-1:0] mkword(input int c, input int s);
        return {8'(c), 24'(s)};
    endfunction

    task automatic expect_word(input int c);
        word_t w;
        w.chan = 2'(c);
        w.data = mkword(c, exp_seq[c]);
        exp_q.push_back(w);
        exp_seq[c]++;
    endtask

    task automatic do_reset(input logic [1:0] s);
        sel = s; rst_n = 1'b0; in_stb = '0; out_ack = 1'b0;
        exc_in = '0; exc_mask = '0; exc_clear = 1'b0;
        for (int c = 0; c < NC; c++) begin
            seq[c] = 0; exp_seq[c] = 0; in_data[c*W +: W] = mkword(c, 0);
        end
        n_xfer = 0; got_q.delete(); exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: observe at negedge, then advance each acked channel's word after the edge.
    task automatic step();
        logic [NC-1:0] took;
        word_t w;
        @(negedge clk);
        took     = in_stb & ack_obs;
        ack_hist = ack_obs;
        if (stb_obs && out_ack) begin
            w.chan = chan_obs; w.data = data_obs; got_q.push_back(w);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            if (took[c]) begin
                n_xfer++; seq[c]++; in_data[c*W +: W] = mkword(c, seq[c]);
            end
        end
    endtask

    task automatic test_reset();
        sel = 0; in_stb = 4'hF; out_ack = 1'b1; exc_in = '0; exc_mask = '0; exc_clear = 1'b0;
        for (int c = 0; c < NC; c++) in_data[c*W +: W] = mkword(c, 0);
        #1 rst_n = 1'b0;
        #2;
        for (int s = 0; s < 3; s++) begin
            n_checks += 2;
            if (ack_a[s] !== 4'b0) begin
                n_fail++; $display("FAIL reset_in_ack dut%0d got %b exp 0000", s, ack_a[s]);
            end
            if (stb_a[s] !== 1'b0) begin
                n_fail++; $display("FAIL reset_out_stb dut%0d got %b exp 0", s, stb_a[s]);
            end
        end
        n_checks += 5;
        if (data_obs !== '0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", data_obs); end
        if (chan_obs !== '0) begin n_fail++; $display("FAIL reset_out_chan got %0d exp 0", chan_obs); end
        if (exc_obs !== 1'b0) begin n_fail++; $display("FAIL reset_exception got %b exp 0", exc_obs); end
        if (first_obs !== '0) begin n_fail++; $display("FAIL reset_exc_first got %0d exp 0", first_obs); end
        if (vld_obs !== 1'b0) begin n_fail++; $display("FAIL reset_exc_first_vld got %b exp 0", vld_obs); end
        $display("reset: in_ack=%b out_stb=%b exception=%b", ack_obs, stb_obs, exc_obs);
    endtask

    task automatic test_round_robin();
        int cyc = 0;
        word_t e, g;
        do_reset(0);
        for (int i = 0; i < 5; i++) expect_word(i % NC);
        in_stb = 4'hF; out_ack = 1'b1;
        while (n_xfer < 5 && cyc < 40) begin
            step(); cyc++;
            if (n_xfer >= 5) in_stb = '0;
        end
        repeat (4) step();
        n_checks += 2;
        if (cyc !== 5) begin n_fail++; $display("FAIL rr_rate got %0d cycles exp 5", cyc); end
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rr_count got %0d words exp %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            $display("rr: chan=%0d data=%h", g.chan, g.data);
            if (g !== e) begin
                n_fail++;
                $display("FAIL rr_order got chan=%0d data=%h exp chan=%0d data=%h", g.chan, g.data, e.chan, e.data);
            end
        end
    endtask

    task automatic test_priority();
        int cyc = 0;
        word_t e, g;
        do_reset(1);
        expect_word(0); expect_word(0); expect_word(0); expect_word(2); expect_word(2);
        in_stb = 4'b0101; out_ack = 1'b1;
        while (n_xfer < 5 && cyc < 40) begin
            step(); cyc++;
            if (seq[0] >= 3) in_stb[0] = 1'b0;
            if (n_xfer >= 5) in_stb = '0;
        end
        repeat (4) step();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL prio_count got %0d words exp %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            $display("prio: chan=%0d data=%h", g.chan, g.data);
            if (g !== e) begin
                n_fail++;
                $display("FAIL prio_order got chan=%0d data=%h exp chan=%0d data=%h", g.chan, g.data, e.chan, e.data);
            end
        end
    endtask

    task automatic test_burst();
        word_t e, g;
        for (int part = 0; part < 2; part++) begin
            int cyc = 0;
            int total = (part == 0) ? 7 : 5;
            do_reset(2);
            if (part == 0) begin
                expect_word(1); expect_word(1); expect_word(1);
                expect_word(3); expect_word(3); expect_word(3); expect_word(1);
            end else begin
                expect_word(1); expect_word(1); expect_word(3); expect_word(3); expect_word(3);
            end
            in_stb = 4'b1010; out_ack = 1'b1;
            while (n_xfer < total && cyc < 40) begin
                step(); cyc++;
                if (part == 1 && seq[1] >= 2) in_stb[1] = 1'b0;
                if (n_xfer >= total) in_stb = '0;
            end
            repeat (4) step();
            n_checks++;
            if (got_q.size() !== exp_q.size()) begin
                n_fail++; $display("FAIL burst%0d_count got %0d words exp %0d", part, got_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
                $display("burst%0d: chan=%0d data=%h", part, g.chan, g.data);
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL burst%0d_order got chan=%0d data=%h exp chan=%0d data=%h", part, g.chan, g.data, e.chan, e.data);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        int cyc = 0;
        word_t e, g;
        do_reset(0);
        for (int i = 0; i < 5; i++) expect_word(0);
        in_stb = 4'b0001; out_ack = 1'b0;
        repeat (8) step();
        n_checks += 4;
        if (n_xfer !== 4) begin n_fail++; $display("FAIL full_accepts got %0d exp 4", n_xfer); end
        if (ack_hist !== 4'b0) begin n_fail++; $display("FAIL full_in_ack got %b exp 0000", ack_hist); end
        if (stb_obs !== 1'b1) begin n_fail++; $display("FAIL full_out_stb got %b exp 1", stb_obs); end
        if (data_obs !== mkword(0, 0)) begin
            n_fail++; $display("FAIL full_head_stable got %h exp %h", data_obs, mkword(0, 0));
        end
        out_ack = 1'b1;
        step();
        n_checks++;
        if (ack_hist !== 4'b0) begin n_fail++; $display("FAIL full_pop_push got %b exp 0000", ack_hist); end
        while (n_xfer < 5 && cyc < 20) begin
            step(); cyc++;
            if (n_xfer >= 5) in_stb = '0;
        end
        repeat (6) step();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL drain_count got %0d words exp %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            $display("drain: chan=%0d data=%h", g.chan, g.data);
            if (g !== e) begin
                n_fail++;
                $display("FAIL drain_order got chan=%0d data=%h exp chan=%0d data=%h", g.chan, g.data, e.chan, e.data);
            end
        end
    endtask

    task automatic test_exceptions();
        do_reset(0);
        exc_in = 4'b0100;
        @(posedge clk); #1;
        n_checks += 3;
        if (exc_obs !== 1'b1) begin n_fail++; $display("FAIL exc_rise got %b exp 1", exc_obs); end
        if (first_obs !== 2'd2) begin n_fail++; $display("FAIL exc_first got %0d exp 2", first_obs); end
        if (vld_obs !== 1'b1) begin n_fail++; $display("FAIL exc_first_vld got %b exp 1", vld_obs); end
        exc_in = 4'b0001;
        @(posedge clk); #1;
        n_checks++;
        if (first_obs !== 2'd2) begin n_fail++; $display("FAIL exc_first_hold got %0d exp 2", first_obs); end
        exc_in = 4'b0000; exc_mask = 4'b0101;
        @(posedge clk); #1;
        n_checks++;
        if (exc_obs !== 1'b0) begin n_fail++; $display("FAIL exc_masked got %b exp 0", exc_obs); end
        exc_mask = 4'b0000;
        @(posedge clk); #1;
        n_checks++;
        if (exc_obs !== 1'b1) begin n_fail++; $display("FAIL exc_sticky_kept got %b exp 1", exc_obs); end
        exc_clear = 1'b1;
        @(posedge clk); #1;
        exc_clear = 1'b0;
        n_checks += 2;
        if (vld_obs !== 1'b0) begin n_fail++; $display("FAIL exc_clear_vld got %b exp 0", vld_obs); end
        if (exc_obs !== 1'b0) begin n_fail++; $display("FAIL exc_clear_out got %b exp 0", exc_obs); end
        exc_clear = 1'b1; exc_in = 4'b1000;
        @(posedge clk); #1;
        exc_clear = 1'b0; exc_in = 4'b0000;
        n_checks += 3;
        if (vld_obs !== 1'b1) begin n_fail++; $display("FAIL exc_set_wins_vld got %b exp 1", vld_obs); end
        if (first_obs !== 2'd3) begin n_fail++; $display("FAIL exc_set_wins_first got %0d exp 3", first_obs); end
        if (exc_obs !== 1'b1) begin n_fail++; $display("FAIL exc_set_wins_out got %b exp 1", exc_obs); end
        $display("exc: exception=%b first=%0d vld=%b", exc_obs, first_obs, vld_obs);
    endtask

    task automatic test_reset_mid_burst();
        int cyc = 0;
        do_reset(2);
        out_ack = 1'b0; exc_in = 4'b0010; in_stb = 4'b0001;
        while (n_xfer < 3 && cyc < 30) begin
            step(); cyc++;
            if (n_xfer >= 1) in_stb = 4'b0010;
        end
        exc_in = 4'b0000;
        n_checks += 3;
        if (n_xfer !== 3) begin n_fail++; $display("FAIL mid_fill got %0d exp 3", n_xfer); end
        if (stb_obs !== 1'b1) begin n_fail++; $display("FAIL mid_out_stb got %b exp 1", stb_obs); end
        if (exc_obs !== 1'b1) begin n_fail++; $display("FAIL mid_exception got %b exp 1", exc_obs); end
        rst_n = 1'b0;
        #2;
        n_checks += 6;
        if (ack_obs !== 4'b0) begin n_fail++; $display("FAIL mid_rst_in_ack got %b exp 0000", ack_obs); end
        if (stb_obs !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_stb got %b exp 0", stb_obs); end
        if (data_obs !== '0) begin n_fail++; $display("FAIL mid_rst_out_data got %h exp 0", data_obs); end
        if (chan_obs !== '0) begin n_fail++; $display("FAIL mid_rst_out_chan got %0d exp 0", chan_obs); end
        if (exc_obs !== 1'b0) begin n_fail++; $display("FAIL mid_rst_exception got %b exp 0", exc_obs); end
        if (vld_obs !== 1'b0) begin n_fail++; $display("FAIL mid_rst_exc_vld got %b exp 0", vld_obs); end
        in_stb = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        n_checks++;
        if (stb_obs !== 1'b0) begin n_fail++; $display("FAIL mid_fifo_dropped got %b exp 0", stb_obs); end
        $display("reset_mid: in_ack=%b out_stb=%b", ack_obs, stb_obs);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_priority();
        test_burst();
        test_fifo_full();
        test_exceptions();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
